// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter: valid/ready barrel shifter (SLL/SRL/SRA/ROR) with one register stage per shift-amount bit
// Ports: clk, rst (sync, active-high); in_valid/in_ready/data_in/smt/mode from the producer;
// out_valid/out_ready/data_out to the consumer; carry_out/zero_out only when BSHIFT_FLAGS_EN is defined.
// Latency is SHW cycles: an input register followed by SHW shift stages, all frozen together on a stall.
module pipelined_barrel_shifter #(
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         data_in,
  input  logic [$clog2(WIDTH)-1:0] smt,
  input  logic [1:0]               mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         data_out
`ifdef BSHIFT_FLAGS_EN
  ,
  output logic                     carry_out,
  output logic                     zero_out
`endif
);
  localparam int SHW = $clog2(WIDTH);
  logic [WIDTH-1:0] d [0:SHW];
  logic [WIDTH-1:0] nx [0:SHW-1];
  logic [SHW-1:0] s [0:SHW-1];
  logic [1:0] m [0:SHW-1];
  logic [SHW-1:0] g;
  logic [SHW:0] v;
  logic stall;
`ifdef BSHIFT_FLAGS_EN
  logic [SHW:0] c;
  logic z;
`endif
  assign stall = out_valid & ~out_ready;
  assign in_ready = rst | ~stall;
  assign out_valid = v[SHW];
  assign data_out = d[SHW];
  // g keeps the original sign bit so SRA fills with data_in[WIDTH-1] at every stage
  always_ff @(posedge clk)
    if (rst) begin
      v[0] <= 1'b0;
      d[0] <= '0;
      s[0] <= '0;
      m[0] <= '0;
      g[0] <= 1'b0;
`ifdef BSHIFT_FLAGS_EN
      c[0] <= 1'b0;
`endif
    end else if (!stall) begin
      v[0] <= in_valid;
      d[0] <= data_in;
      s[0] <= smt;
      m[0] <= mode;
      g[0] <= data_in[WIDTH-1];
`ifdef BSHIFT_FLAGS_EN
      c[0] <= 1'b0;
`endif
    end
  for (genvar k = 0; k < SHW; k++) begin : stg
    localparam int SH = 1 << k;
    logic [WIDTH-1:0] srl;
    assign srl = d[k] >> SH;
    // s is shifted right each stage, so bit 0 is always this stage's shift enable
    assign nx[k] = !s[k][0] ? d[k] :
                   m[k] == 2'd0 ? d[k] << SH :
                   m[k] == 2'd1 ? srl :
                   m[k] == 2'd2 ? srl | ({WIDTH{g[k]}} & ~({WIDTH{1'b1}} >> SH)) :
                   srl | (d[k] << (WIDTH - SH));
    always_ff @(posedge clk)
      if (rst) begin
        v[k+1] <= 1'b0;
        d[k+1] <= '0;
`ifdef BSHIFT_FLAGS_EN
        c[k+1] <= 1'b0;
`endif
      end else if (!stall) begin
        v[k+1] <= v[k];
        d[k+1] <= nx[k];
`ifdef BSHIFT_FLAGS_EN
        c[k+1] <= s[k][0] ? (m[k] == 2'd0 ? d[k][WIDTH-SH] : d[k][SH-1]) : c[k];
`endif
      end
    if (k < SHW - 1) begin : fwd
      always_ff @(posedge clk)
        if (rst) begin
          s[k+1] <= '0;
          m[k+1] <= '0;
          g[k+1] <= 1'b0;
        end else if (!stall) begin
          s[k+1] <= s[k] >> 1;
          m[k+1] <= m[k];
          g[k+1] <= g[k];
        end
    end
  end
`ifdef BSHIFT_FLAGS_EN
  always_ff @(posedge clk)
    if (rst) z <= 1'b0;
    else if (!stall) z <= nx[SHW-1] == '0;
  assign carry_out = c[SHW];
  assign zero_out = z;
`endif
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb_pipelined_barrel_shifter: directed WIDTH=8 vectors and corner sequences, random WIDTH=32 against a reference model
module tb_pipelined_barrel_shifter;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;
  int n_vec = 0, n_bad = 0;
  typedef struct {
    logic [63:0] d;
    logic c;
    logic z;
    int acc;
    bit lat;
  } exp_t;
  typedef struct {
    logic [7:0] d;
    logic [2:0] s;
    logic [1:0] m;
    logic [7:0] ed;
    logic ec;
    logic ez;
  } vec_t;
  exp_t sb8[$], sb32[$];
  exp_t e8, e32;
  vec_t tbl [13];
  logic v8, ir8, ov8, or8;
  logic [7:0] d8, dout8, hold8;
  logic [2:0] s8;
  logic [1:0] m8;
  logic v32, ir32, ov32, or32;
  logic [31:0] d32, dout32, hold32;
  logic [4:0] s32;
  logic [1:0] m32;
  bit st8 = 0, st32 = 0;
`ifdef BSHIFT_FLAGS_EN
  logic c8, z8, c32, z32;
`endif
  pipelined_barrel_shifter #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(ir8), .data_in(d8), .smt(s8), .mode(m8),
    .out_valid(ov8), .out_ready(or8), .data_out(dout8)
`ifdef BSHIFT_FLAGS_EN
    , .carry_out(c8), .zero_out(z8)
`endif
  );
  pipelined_barrel_shifter #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .in_valid(v32), .in_ready(ir32), .data_in(d32), .smt(s32), .mode(m32),
    .out_valid(ov32), .out_ready(or32), .data_out(dout32)
`ifdef BSHIFT_FLAGS_EN
    , .carry_out(c32), .zero_out(z32)
`endif
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // returns {carry, result} straight from the single-step shift definitions
  function automatic logic [64:0] model(input int w, input logic [63:0] din, input int s, input logic [1:0] md);
    logic [63:0] mask = (64'd1 << w) - 64'd1;
    logic [63:0] d = din & mask;
    logic [63:0] r;
    logic c;
    case (md)
      2'd0: r = (d << s) & mask;
      2'd1: r = d >> s;
      2'd2: r = (d >> s) | (d[w-1] ? (mask & ~(mask >> s)) : 64'd0);
      default: r = (s == 0) ? d : (((d >> s) | (d << (w - s))) & mask);
    endcase
    c = (s == 0) ? 1'b0 : (md == 2'd0) ? d[w-s] : (md == 2'd3) ? r[w-1] : d[s-1];
    return {c, r};
  endfunction
  function automatic exp_t mk(input logic [64:0] r, input bit lat);
    exp_t e;
    e.d = r[63:0];
    e.c = r[64];
    e.z = r[63:0] == 64'd0;
    e.acc = 0;
    e.lat = lat;
    return e;
  endfunction
  task automatic send8(input logic [7:0] d, input logic [2:0] s, input logic [1:0] m, input exp_t e);
    int w = 0;
    v8 = 1'b1; d8 = d; s8 = s; m8 = m;
    @(negedge clk);
    while (!ir8 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!ir8) chk("accept8_timeout", ir8, 1);
    else begin
      e.acc = cyc + 1;
      sb8.push_back(e);
    end
    @(posedge clk);
    #1 v8 = 1'b0;
  endtask
  task automatic drain8();
    int w = 0;
    while (sb8.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("drain8", sb8.size(), 0);
  endtask
  task automatic drain32();
    int w = 0;
    while (sb32.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("drain32", sb32.size(), 0);
  endtask
  always @(negedge clk) begin
    if (rst) begin
      sb8.delete();
      st8 = 0;
    end else begin
      if (st8) chk("hold8", dout8, hold8);
      st8 = ov8 && !or8;
      hold8 = dout8;
      if (st8) chk("stall_inready8", ir8, 0);
      if (ov8 && or8) begin
        if (sb8.size() == 0) chk("spurious8", ov8, 0);
        else begin
          e8 = sb8.pop_front();
          chk("data8", dout8, e8.d);
`ifdef BSHIFT_FLAGS_EN
          chk("carry8", c8, e8.c);
          chk("zero8", z8, e8.z);
`endif
          if (e8.lat) chk("latency8", cyc - e8.acc, 3);
        end
      end
    end
  end
  always @(negedge clk) begin
    if (rst) begin
      sb32.delete();
      st32 = 0;
    end else begin
      if (st32) chk("hold32", dout32, hold32);
      st32 = ov32 && !or32;
      hold32 = dout32;
      if (st32) chk("stall_inready32", ir32, 0);
      if (ov32 && or32) begin
        if (sb32.size() == 0) chk("spurious32", ov32, 0);
        else begin
          e32 = sb32.pop_front();
          chk("data32", dout32, e32.d);
`ifdef BSHIFT_FLAGS_EN
          chk("carry32", c32, e32.c);
          chk("zero32", z32, e32.z);
`endif
          if (e32.lat) chk("latency32", cyc - e32.acc, 5);
        end
      end
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    exp_t e;
    int acc = 0;
    tbl = '{
      '{8'hAA, 3'd3, 2'd0, 8'h50, 1'b1, 1'b0},
      '{8'hAA, 3'd2, 2'd1, 8'h2A, 1'b1, 1'b0},
      '{8'hF0, 3'd1, 2'd2, 8'hF8, 1'b0, 1'b0},
      '{8'hD5, 3'd3, 2'd3, 8'hBA, 1'b1, 1'b0},
      '{8'h5A, 3'd0, 2'd0, 8'h5A, 1'b0, 1'b0},
      '{8'h5A, 3'd0, 2'd1, 8'h5A, 1'b0, 1'b0},
      '{8'h5A, 3'd0, 2'd2, 8'h5A, 1'b0, 1'b0},
      '{8'h5A, 3'd0, 2'd3, 8'h5A, 1'b0, 1'b0},
      '{8'h01, 3'd1, 2'd1, 8'h00, 1'b1, 1'b1},
      '{8'h81, 3'd7, 2'd3, 8'h03, 1'b0, 1'b0},
      '{8'hFF, 3'd7, 2'd0, 8'h80, 1'b1, 1'b0},
      '{8'h80, 3'd7, 2'd2, 8'hFF, 1'b0, 1'b0},
      '{8'h40, 3'd6, 2'd2, 8'h01, 1'b0, 1'b0}
    };
    v8 = 1'b1; d8 = 8'hFF; s8 = 3'd1; m8 = 2'd0; or8 = 1'b1;
    v32 = 1'b0; d32 = '0; s32 = '0; m32 = '0; or32 = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid8", ov8, 0);
    chk("rst_data8", dout8, 0);
    chk("rst_in_ready8", ir8, 1);
    chk("rst_out_valid32", ov32, 0);
    chk("rst_data32", dout32, 0);
    chk("rst_in_ready32", ir32, 1);
`ifdef BSHIFT_FLAGS_EN
    chk("rst_carry8", c8, 0);
    chk("rst_zero8", z8, 0);
`endif
    @(posedge clk);
    #1 rst = 1'b0; v8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 13; i++) begin
      e.d = 64'(tbl[i].ed); e.c = tbl[i].ec; e.z = tbl[i].ez; e.acc = 0; e.lat = 1;
      send8(tbl[i].d, tbl[i].s, tbl[i].m, e);
    end
    drain8();
    @(posedge clk);
    #1;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          logic [7:0] rd = 8'($urandom);
          logic [2:0] rs = 3'($urandom);
          logic [1:0] rm = 2'($urandom);
          send8(rd, rs, rm, mk(model(8, 64'(rd), int'(rs), rm), 0));
        end
      end
      begin
        repeat (4) @(posedge clk);
        #1 or8 = 1'b0;
        repeat (4) @(posedge clk);
        #1 or8 = 1'b1;
      end
    join
    drain8();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) send8(8'hC3, 3'(i + 1), 2'd1, mk(model(8, 64'hC3, i + 1, 2'd1), 0));
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_flush_valid8", ov8, 0);
    chk("rst_flush_data8", dout8, 0);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1 send8(8'h96, 3'd4, 2'd3, mk(model(8, 64'h96, 4, 2'd3), 1));
    drain8();
    @(posedge clk);
    #1 v32 = 1'b1; d32 = 32'h8000_0001; s32 = 5'd31; m32 = 2'd2;
    @(negedge clk);
    e = mk(model(32, 64'h8000_0001, 31, 2'd2), 1);
    e.acc = cyc + 1;
    if (ir32) sb32.push_back(e);
    chk("accept32", ir32, 1);
    @(posedge clk);
    #1 v32 = 1'b0;
    drain32();
    while (acc < 1000 && cyc < 20000) begin
      @(posedge clk);
      #1;
      v32 = $urandom_range(0, 3) != 0;
      d32 = $urandom;
      s32 = 5'($urandom);
      m32 = 2'($urandom);
      or32 = $urandom_range(0, 3) != 0;
      @(negedge clk);
      if (v32 && ir32) begin
        sb32.push_back(mk(model(32, 64'(d32), int'(s32), m32), 0));
        acc++;
      end
    end
    chk("ops32_issued", acc, 1000);
    @(posedge clk);
    #1 v32 = 1'b0; or32 = 1'b1;
    drain32();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
